// File: rtl/mips_pipeline.sv
// Four-stage MIPS subset pipeline (IF, ID, EX, WB) with a writable instruction memory.
// Define MIPS_PIPELINE_FORWARDING_EN to forward the EX result into ID operand capture.
module mips_pipeline #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int NB_REG     = 5
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_imem_write,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_imem_addr,
    input  logic [31:0]                   i_imem_data,
    input  logic [NB_REG-1:0]             i_debug_reg_addr,
    output logic [NB_DATA-1:0]            o_debug_reg_data,
    output logic [NB_ADDR-1:0]            o_pc,
    output logic                          o_halted,
    output logic [31:0]                   o_cycle_count
);

    localparam int NB_IDX   = $clog2(IMEM_DEPTH);
    localparam int NUM_REGS = 2 ** NB_REG;
    localparam logic [NB_ADDR-1:0] PC_MASK = NB_ADDR'(4 * IMEM_DEPTH - 1);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;

    typedef struct packed {
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [2:0]         op;
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
        logic [NB_REG-1:0]  rd;
        logic               we;
        logic               halt;
    } id_ex_t;

    typedef struct packed {
        logic [NB_DATA-1:0] val;
        logic [NB_REG-1:0]  rd;
        logic               we;
        logic               halt;
    } ex_wb_t;

    logic [31:0]        imem [IMEM_DEPTH];
    logic [NB_DATA-1:0] regs [NUM_REGS];

    if_id_t if_id;
    id_ex_t id_ex, id_next;
    ex_wb_t ex_wb, ex_next;

    logic                advance;
    logic                fetch_hold;
    logic [31:0]         fetch_word;
    logic [NB_ADDR-1:0]  pc_inc;

    logic [31:0]         instr;
    logic [5:0]          opcode, funct;
    logic [NB_REG-1:0]   rs, rt, rd;
    logic [15:0]         imm;
    logic                is_r;
    logic [NB_DATA-1:0]  sext_imm, zext_imm;
    logic [NB_DATA-1:0]  rs_rf, rt_rf, rs_val, rt_val;
    logic [NB_DATA-1:0]  ex_val;

    assign advance    = i_enable && !o_halted;
    // Once HALT reaches ID, nothing further is fetched until reset.
    assign fetch_hold = (instr == HALT_WORD) || id_ex.halt || ex_wb.halt;
    assign fetch_word = imem[o_pc[NB_IDX+1:2]];
    assign pc_inc     = (o_pc + NB_ADDR'(4)) & PC_MASK;

    assign instr    = if_id.instr;
    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rs       = NB_REG'(instr[25:21]);
    assign rt       = NB_REG'(instr[20:16]);
    assign rd       = NB_REG'(instr[15:11]);
    assign imm      = instr[15:0];
    assign is_r     = (opcode == 6'h00);
    assign sext_imm = NB_DATA'($signed(imm));
    assign zext_imm = NB_DATA'(imm);

    // WB write is visible to the ID read in the same cycle.
    assign rs_rf = (ex_wb.we && ex_wb.rd != '0 && ex_wb.rd == rs) ? ex_wb.val : regs[rs];
    assign rt_rf = (ex_wb.we && ex_wb.rd != '0 && ex_wb.rd == rt) ? ex_wb.val : regs[rt];

`ifdef MIPS_PIPELINE_FORWARDING_EN
    assign rs_val = (id_ex.we && id_ex.rd != '0 && id_ex.rd == rs) ? ex_val : rs_rf;
    assign rt_val = (id_ex.we && id_ex.rd != '0 && id_ex.rd == rt) ? ex_val : rt_rf;
`else
    assign rs_val = rs_rf;
    assign rt_val = rt_rf;
`endif

    assign o_debug_reg_data = regs[i_debug_reg_addr];

    always_comb begin
        id_next      = '0;
        id_next.a    = rs_val;
        id_next.b    = rt_val;
        id_next.rd   = rd;
        id_next.halt = (instr == HALT_WORD);
        unique case (1'b1)
            is_r && funct == 6'h21: begin id_next.op = OP_ADD; id_next.we = 1'b1; end
            is_r && funct == 6'h23: begin id_next.op = OP_SUB; id_next.we = 1'b1; end
            is_r && funct == 6'h24: begin id_next.op = OP_AND; id_next.we = 1'b1; end
            is_r && funct == 6'h25: begin id_next.op = OP_OR;  id_next.we = 1'b1; end
            is_r && funct == 6'h26: begin id_next.op = OP_XOR; id_next.we = 1'b1; end
            is_r && funct == 6'h2A: begin id_next.op = OP_SLT; id_next.we = 1'b1; end
            opcode == 6'h08: begin
                id_next.op = OP_ADD;
                id_next.b  = sext_imm;
                id_next.rd = rt;
                id_next.we = 1'b1;
            end
            opcode == 6'h0D: begin
                id_next.op = OP_OR;
                id_next.b  = zext_imm;
                id_next.rd = rt;
                id_next.we = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (id_ex.op)
            OP_SUB:  ex_val = id_ex.a - id_ex.b;
            OP_AND:  ex_val = id_ex.a & id_ex.b;
            OP_OR:   ex_val = id_ex.a | id_ex.b;
            OP_XOR:  ex_val = id_ex.a ^ id_ex.b;
            OP_SLT:  ex_val = NB_DATA'($signed(id_ex.a) < $signed(id_ex.b));
            default: ex_val = id_ex.a + id_ex.b;
        endcase
        ex_next      = '0;
        ex_next.val  = ex_val;
        ex_next.rd   = id_ex.rd;
        ex_next.we   = id_ex.we;
        ex_next.halt = id_ex.halt;
    end

    always_ff @(posedge i_clk) begin
        if (i_imem_write) begin
            imem[i_imem_addr] <= i_imem_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pc          <= '0;
            if_id         <= '0;
            id_ex         <= '0;
            ex_wb         <= '0;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (advance) begin
            o_pc        <= fetch_hold ? o_pc : pc_inc;
            if_id.instr <= fetch_hold ? 32'h0 : fetch_word;
            id_ex       <= id_next;
            ex_wb       <= ex_next;
            if (ex_wb.we && ex_wb.rd != '0) begin
                regs[ex_wb.rd] <= ex_wb.val;
            end
            if (ex_wb.halt) begin
                o_halted <= 1'b1;
            end
            if (o_cycle_count != 32'hFFFF_FFFF) begin
                o_cycle_count <= o_cycle_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/mips_pipeline.md
MIPS_PIPELINE -- requirements
Module: mips_pipeline

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, datapath/register width (legal range 16..64).
REQ-002 SHALL have parameter NB_ADDR, default 32, PC width.
REQ-003 SHALL have parameter IMEM_DEPTH, default 64, instruction memory depth in words (power of two).
REQ-004 SHALL have parameter NB_REG, default 5, register index width (2**NB_REG registers).
REQ-005 SHALL have port i_clk input 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset input 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_enable input 1: pipeline advance; low freezes all pipeline state.
REQ-008 SHALL have port i_imem_write input 1: instruction memory write strobe.
REQ-009 SHALL have port i_imem_addr input $clog2(IMEM_DEPTH): instruction memory word address.
REQ-010 SHALL have port i_imem_data input 32: instruction word to write.
REQ-011 SHALL have port i_debug_reg_addr input NB_REG: register file debug read index.
REQ-012 SHALL have port o_debug_reg_data output NB_DATA: combinational read of the indexed register.
REQ-013 SHALL have port o_pc output NB_ADDR: current fetch PC (byte address).
REQ-014 SHALL have port o_halted output 1: high once HALT has retired; sticky.
REQ-015 SHALL have port o_cycle_count output 32: enabled, non-halted cycle count.

Function
REQ-016 SHALL implement four stages, IF, ID, EX, WB, separated by IF/ID, ID/EX and EX/WB registers.
REQ-017 SHALL latch imem[PC[..2] mod IMEM_DEPTH] into IF/ID and set PC += 4 on each enabled edge; PC wraps modulo 4*IMEM_DEPTH.
REQ-018 SHALL write an instruction fetched at edge N to the register file at edge N+3, giving a fetch-to-write latency of 3 enabled cycles.
REQ-019 SHALL decode R-type (opcode 0) funct 0x21 ADDU, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR and 0x2A SLT (signed), with destination rd.
REQ-020 SHALL decode opcode 0x08 ADDI (sign-extended imm16) and 0x0D ORI (zero-extended imm16), with destination rt.
REQ-021 SHALL wrap ADD/SUB results modulo 2**NB_DATA, and SLT SHALL yield 1 or 0.
REQ-022 SHALL treat any other encoding, including 0x00000000, as a NOP with no register write.
REQ-023 SHALL ignore writes to register 0, which SHALL always read 0.
REQ-024 SHALL make a WB write visible to an ID read in the same cycle (write-through).
REQ-025 SHALL, on HALT (0xFFFFFFFF) decoded in ID: freeze PC, load NOPs into IF/ID thereafter, and assert o_halted at the edge where HALT leaves WB.
REQ-026 SHALL keep the pipeline frozen while o_halted is high, until reset.
REQ-027 SHALL accept an imem write in any cycle, enabled or not; a fetch of the same address in the same cycle SHALL return the old word.
REQ-028 SHALL, when i_enable is low, hold PC, pipeline registers, register file and counter.
REQ-029 SHALL increment o_cycle_count on enabled, non-halted edges and saturate it at 0xFFFFFFFF.

Reset
REQ-030 SHALL, on i_reset, clear PC, all pipeline registers (to NOP), all registers, o_halted and o_cycle_count to 0; imem contents SHALL be retained.
REQ-031 SHALL have reset take priority over i_enable, HALT and an in-flight instruction; the first fetch after reset is from address 0.

Configuration
REQ-032 SHALL, with macro MIPS_PIPELINE_FORWARDING_EN defined, forward the EX result into ID/EX operand capture when the EX destination is non-zero and equals rs/rt, so back-to-back dependent instructions are correct.
REQ-033 SHALL, without MIPS_PIPELINE_FORWARDING_EN, omit forwarding; an ID read then returns the pre-EX value, and software SHALL place one independent instruction between dependent pairs.

Verification
REQ-034 SHALL be verified by: load ADDI r1,r0,5; ADDI r2,r0,7; NOP; ADDU r3,r1,r2; HALT -> after halt r3=12, o_halted=1.
REQ-035 SHALL be verified by: with FORWARDING_EN, ADDI r1,r0,3; ADDU r2,r1,r1 -> r2=6; without the macro, r2=0.
REQ-036 SHALL be verified by: ADDI r1,r0,-1; SLT r2,r1,r0; SUBU r3,r0,r1 (spaced by NOPs) -> r1=all-ones, r2=1, r3=1.
REQ-037 SHALL be verified by: ADDI r0,r0,9 -> r0 reads 0; ORI r4,r0,0x8000 -> r4=0x00008000.
REQ-038 SHALL be verified by: hold i_enable low 10 cycles mid-program -> PC, count and registers unchanged; resume gives the same final state as an uninterrupted run.
REQ-039 SHALL be verified by: assert i_reset two cycles after HALT decode -> o_halted=0, PC=0, count=0, registers zero; the program reruns from imem unchanged.
